// File: rtl/muldiv_fu_if.sv
// muldiv_fu_if: issue handshake from the reservation station plus the result/grant
// handshake toward the CDB.
//   master: the RS/CDB side (drives the issue fields and B_grant).
//   slave : the functional unit (drives RS_ready and the B_ result fields).
interface muldiv_fu_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ROB_LOG = 4
);
  logic               RS_valid;
  logic               RS_ready;
  logic [2:0]         RS_op;
  logic [XLEN-1:0]    RS_Vj;
  logic [XLEN-1:0]    RS_Vk;
  logic [ROB_LOG-1:0] RS_DestRob;
  logic               B_enable;
  logic [XLEN-1:0]    B_value;
  logic [ROB_LOG-1:0] B_RobId;
  logic               B_grant;

  modport master (
    output RS_valid, RS_op, RS_Vj, RS_Vk, RS_DestRob, B_grant,
    input  RS_ready, B_enable, B_value, B_RobId
  );

  modport slave (
    input  RS_valid, RS_op, RS_Vj, RS_Vk, RS_DestRob, B_grant,
    output RS_ready, B_enable, B_value, B_RobId
  );
endinterface

// File: rtl/muldiv_fu.sv
// muldiv_fu: RV32M multiply/divide functional unit.
// Multiplies go through a fixed MUL_LAT-deep pipeline; divides use an iterative
// radix-2 restoring divider. Results are queued in an output FIFO for the CDB.
// Ports:
//   clk_in   - clock
//   rst_in   - synchronous active-high reset
//   rdy_in   - global enable; low freezes all state
//   clear_in - misprediction flush (same datapath effect as reset)
//   bus      - RS issue handshake and CDB result/grant (slave side)
module muldiv_fu #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROB_LOG   = 4,
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned OUT_DEPTH = 4
) (
  input logic        clk_in,
  input logic        rst_in,
  input logic        rdy_in,
  input logic        clear_in,
  muldiv_fu_if.slave bus
);
  localparam int unsigned PW  = $clog2(OUT_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned UW  = $clog2(OUT_DEPTH + MUL_LAT + 1) + 1;
  localparam int unsigned NW  = $clog2(XLEN);
  localparam int unsigned PrW = 2 * XLEN;
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StFix} div_state_e;

  logic [MUL_LAT-1:0] mul_vld_q;
  logic [XLEN-1:0]    mul_res_q [MUL_LAT];
  logic [ROB_LOG-1:0] mul_rob_q [MUL_LAT];

  div_state_e         div_state_q, div_state_d;
  logic [XLEN-1:0]    quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [NW-1:0]      div_cnt_q, div_cnt_d;
  logic [ROB_LOG-1:0] div_rob_q, div_rob_d;
  logic               div_neg_q, div_neg_d, div_rem_q, div_rem_d, div_spec_q, div_spec_d;

  logic [XLEN-1:0]    fifo_val_q [OUT_DEPTH];
  logic [ROB_LOG-1:0] fifo_rob_q [OUT_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      fifo_cnt_q;

  logic               div_busy, rs_ready, accept, mul_acc, div_acc;
  logic               mul_push, div_push, push, pop, b_enable;
  logic [UW-1:0]      credits_used;
  logic [XLEN-1:0]    mul_res, fix_val, push_val, div_mag;
  logic [ROB_LOG-1:0] push_rob;
  logic signed [XLEN:0] a_ext, b_ext;
  logic [PrW-1:0]     prod;
  logic [XLEN:0]      r_sh, diff;
  logic               op_signed, a_neg, b_neg;

  // Every op in flight or queued holds one FIFO slot, so a push can never overflow.
  always_comb begin
    credits_used = UW'(fifo_cnt_q) + UW'(div_busy);
    for (int i = 0; i < MUL_LAT; i++) begin
      credits_used = credits_used + UW'(mul_vld_q[i]);
    end
  end

  assign div_busy = (div_state_q != StIdle);
  assign rs_ready = !div_busy && (credits_used < UW'(OUT_DEPTH));
  assign accept   = bus.RS_valid && rs_ready;
  assign mul_acc  = accept && !bus.RS_op[2];
  assign div_acc  = accept && bus.RS_op[2];

  // Multiply: sign-extend each operand by one bit as the op demands; the low 2*XLEN
  // bits of the extended product are exact for every signedness combination.
  always_comb begin
    a_ext   = {(bus.RS_op[1:0] == 2'd1 || bus.RS_op[1:0] == 2'd2) & bus.RS_Vj[XLEN-1],
               bus.RS_Vj};
    b_ext   = {(bus.RS_op[1:0] == 2'd1) & bus.RS_Vk[XLEN-1], bus.RS_Vk};
    prod    = PrW'(a_ext) * PrW'(b_ext);
    mul_res = (bus.RS_op[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[PrW-1:XLEN];
  end

  assign op_signed = !bus.RS_op[0];
  assign a_neg     = op_signed && bus.RS_Vj[XLEN-1];
  assign b_neg     = op_signed && bus.RS_Vk[XLEN-1];
  assign r_sh      = {rem_q, quo_q[XLEN-1]};
  assign diff      = r_sh - {1'b0, dvs_q};

  always_comb begin
    div_state_d = div_state_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    div_cnt_d   = div_cnt_q;
    div_rob_d   = div_rob_q;
    div_neg_d   = div_neg_q;
    div_rem_d   = div_rem_q;
    div_spec_d  = div_spec_q;
    unique case (div_state_q)
      StIdle: begin
        if (div_acc) begin
          div_rob_d   = bus.RS_DestRob;
          div_rem_d   = bus.RS_op[1];
          div_cnt_d   = '0;
          div_spec_d  = 1'b0;
          rem_d       = '0;
          quo_d       = a_neg ? -bus.RS_Vj : bus.RS_Vj;
          dvs_d       = b_neg ? -bus.RS_Vk : bus.RS_Vk;
          // Quotient sign from both operands, remainder sign from the dividend.
          div_neg_d   = bus.RS_op[1] ? a_neg : (a_neg ^ b_neg);
          div_state_d = StRun;
          // Special cases skip the iteration; quo_q carries the final result.
          if (bus.RS_Vk == '0) begin
            div_spec_d  = 1'b1;
            quo_d       = bus.RS_op[1] ? bus.RS_Vj : '1;
            div_state_d = StFix;
          end else if (op_signed && bus.RS_Vj == MinInt && bus.RS_Vk == '1) begin
            div_spec_d  = 1'b1;
            quo_d       = bus.RS_op[1] ? '0 : MinInt;
            div_state_d = StFix;
          end
        end
      end
      StRun: begin
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = r_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + NW'(1);
        if (div_cnt_q == NW'(XLEN - 1)) begin
          div_state_d = StFix;
        end
      end
      StFix: begin
        // A retiring multiply owns the FIFO write port; retry next edge.
        if (!mul_push) begin
          div_state_d = StIdle;
        end
      end
      default: div_state_d = StIdle;
    endcase
  end

  assign div_mag  = div_rem_q ? rem_q : quo_q;
  assign fix_val  = div_spec_q ? quo_q : (div_neg_q ? -div_mag : div_mag);
  assign mul_push = mul_vld_q[MUL_LAT-1];
  assign div_push = (div_state_q == StFix) && !mul_push;
  assign push     = mul_push || div_push;
  assign push_val = mul_push ? mul_res_q[MUL_LAT-1] : fix_val;
  assign push_rob = mul_push ? mul_rob_q[MUL_LAT-1] : div_rob_q;
  assign b_enable = (fifo_cnt_q != '0);
  assign pop      = b_enable && bus.B_grant;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      mul_vld_q   <= '0;
      div_state_q <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else if (rdy_in) begin
      for (int i = MUL_LAT - 1; i > 0; i--) begin
        mul_vld_q[i] <= mul_vld_q[i-1];
        mul_res_q[i] <= mul_res_q[i-1];
        mul_rob_q[i] <= mul_rob_q[i-1];
      end
      mul_vld_q[0] <= mul_acc;
      mul_res_q[0] <= mul_res;
      mul_rob_q[0] <= bus.RS_DestRob;
      div_state_q  <= div_state_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      dvs_q        <= dvs_d;
      div_cnt_q    <= div_cnt_d;
      div_rob_q    <= div_rob_d;
      div_neg_q    <= div_neg_d;
      div_rem_q    <= div_rem_d;
      div_spec_q   <= div_spec_d;
      if (push) begin
        fifo_val_q[wr_ptr_q] <= push_val;
        fifo_rob_q[wr_ptr_q] <= push_rob;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign bus.RS_ready = rs_ready;
  assign bus.B_enable = b_enable;
  assign bus.B_value  = b_enable ? fifo_val_q[rd_ptr_q] : '0;
  assign bus.B_RobId  = b_enable ? fifo_rob_q[rd_ptr_q] : '0;
endmodule
